// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB requester and the timer it drives.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_TIMEOUT    = 15;

  localparam logic [2:0] ADDR_TDR = 3'b010;
  localparam logic [2:0] ADDR_TCR = 3'b011;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; flags the ACCESS edge on which the count reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // A zero TIMEOUT still needs a 1-bit counter to stay legal; expiry is masked off.
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SAT = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam logic [CW-1:0] SAT_V  = CW'(SAT);
  localparam logic [CW-1:0] LAST_V = CW'(SAT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != SAT_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is the edge whose increment would land on TIMEOUT.
  assign expired = (TIMEOUT != 0) && en && !clr && (count_q == LAST_V);

endmodule

// File: rtl/apb_master_8bit.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS transfer, one response out.
// Handshakes: a beat transfers on a rising edge where valid && ready; valid holds its payload until then.
module apb_master_8bit
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  apb_state_e            state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic wait_en;
  logic expired;

  assign cmd_ready = (state_q == ST_IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign wait_en   = (state_q == ST_ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (pclk),
    .rst    (preset),
    .clr    (accept),
    .en     (wait_en),
    .expired(expired)
  );

  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Completion is checked first so pready wins over a coincident expiry.
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (expired) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign rsp_valid   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_apb_master_8bit.sv
// Directed bench for apb_master_8bit with TIMEOUT = 4 and a hand-driven APB responder.
module tb_apb_master_8bit;
  import apb_master_pkg::*;

  logic       pclk;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       busy;
  logic [1:0] state_dbg;

  int vectors;
  int miscompares;

  apb_master_8bit #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .TIMEOUT   (4)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command and take it on the next edge (caller ensures the master is idle).
  task automatic issue(input logic w, input logic [2:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 8'hFF;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    preset      = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 3'd0;
    cmd_wdata   = 8'd0;
    rsp_ready   = 1'b1;
    prdata      = 8'd0;
    pready      = 1'b0;
    pslverr     = 1'b0;

    // Reset state, sampled while preset is still high.
    tick();
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_paddr", {29'd0, paddr}, 32'd0);
    preset = 1'b0;
    #1;
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait write TDR = 0x5A.
    pready = 1'b1;
    issue(1'b1, ADDR_TDR, 8'h5A);
    check("zw_c1_psel", {31'd0, psel}, 32'd1);
    check("zw_c1_penable", {31'd0, penable}, 32'd0);
    check("zw_c1_paddr", {29'd0, paddr}, 32'd2);
    check("zw_c1_pwdata", {24'd0, pwdata}, 32'h5A);
    check("zw_c1_pwrite", {31'd0, pwrite}, 32'd1);
    check("zw_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("zw_c1_state", {30'd0, state_dbg}, 32'd1);
    tick();
    check("zw_c2_penable", {31'd0, penable}, 32'd1);
    check("zw_c2_psel", {31'd0, psel}, 32'd1);
    check("zw_c2_pwdata", {24'd0, pwdata}, 32'h5A);
    check("zw_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("zw_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("zw_c3_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("zw_c3_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("zw_c3_psel", {31'd0, psel}, 32'd0);
    check("zw_c3_paddr", {29'd0, paddr}, 32'd2);
    tick();
    check("zw_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("zw_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Wait-state read of TCR: three low pready edges, then 0xA1.
    pready = 1'b0;
    prdata = 8'h00;
    issue(1'b0, ADDR_TCR, 8'h77);
    check("ws_pwdata_zero_on_read", {24'd0, pwdata}, 32'd0);
    check("ws_pwrite", {31'd0, pwrite}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("ws_wait_penable", {31'd0, penable}, 32'd1);
      check("ws_wait_paddr", {29'd0, paddr}, 32'd3);
      check("ws_wait_pwrite", {31'd0, pwrite}, 32'd0);
    end
    pready = 1'b1;
    prdata = 8'hA1;
    tick();
    check("ws_rsp_valid_lat6", {31'd0, rsp_valid}, 32'd1);
    check("ws_rsp_rdata", {24'd0, rsp_rdata}, 32'hA1);
    check("ws_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    tick();

    // Slave error on address 7.
    pslverr = 1'b1;
    prdata  = 8'h00;
    issue(1'b1, 3'b111, 8'h11);
    tick();
    tick();
    check("se_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("se_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("se_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    pslverr = 1'b0;
    tick();

    // Timeout: pready stuck low, abort 6 cycles after accept.
    pready = 1'b0;
    prdata = 8'hEE;
    issue(1'b0, ADDR_TDR, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check("to_wait_psel", {31'd0, psel}, 32'd1);
    tick();
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    check("to_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("to_psel", {31'd0, psel}, 32'd0);
    check("to_penable", {31'd0, penable}, 32'd0);
    tick();

    // Boundary: pready rises on the edge where the count would reach TIMEOUT.
    prdata = 8'h77;
    issue(1'b0, ADDR_TCR, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) tick();
    pready = 1'b1;
    tick();
    check("tb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("tb_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("tb_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("tb_rsp_rdata", {24'd0, rsp_rdata}, 32'h77);
    tick();

    // Back-pressure, then a queued TCR = 0x31 write.
    rsp_ready = 1'b0;
    prdata    = 8'h00;
    issue(1'b1, ADDR_TDR, 8'h33);
    tick();
    tick();
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = ADDR_TCR;
    cmd_wdata = 8'h31;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_hold_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      check("bp_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_hold_psel", {31'd0, psel}, 32'd0);
      check("bp_hold_pwdata", {24'd0, pwdata}, 32'h33);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_hs_psel", {31'd0, psel}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("b2b_setup_psel", {31'd0, psel}, 32'd1);
    check("b2b_setup_penable", {31'd0, penable}, 32'd0);
    check("b2b_setup_paddr", {29'd0, paddr}, 32'd3);
    check("b2b_setup_pwdata", {24'd0, pwdata}, 32'h31);
    tick();
    tick();
    check("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    tick();

    // Reset in the middle of ACCESS.
    pready = 1'b0;
    issue(1'b1, ADDR_TDR, 8'h44);
    tick();
    check("rm_in_access", {31'd0, penable}, 32'd1);
    preset = 1'b1;
    tick();
    check("rm_psel", {31'd0, psel}, 32'd0);
    check("rm_penable", {31'd0, penable}, 32'd0);
    check("rm_pwrite", {31'd0, pwrite}, 32'd0);
    check("rm_paddr", {29'd0, paddr}, 32'd0);
    check("rm_pwdata", {24'd0, pwdata}, 32'd0);
    check("rm_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    preset = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rm_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rm_after_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end
    prdata = 8'h5C;
    issue(1'b0, ADDR_TCR, 8'h00);
    check("rm_next_psel", {31'd0, psel}, 32'd1);
    tick();
    tick();
    check("rm_next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rm_next_rsp_rdata", {24'd0, rsp_rdata}, 32'h5C);
    check("rm_next_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    check("rm_next_idle", {30'd0, state_dbg}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
